axa_fetch_decode: RTL and testbench

Front-end stage of the pipelined AXA core, directly upstream of the execute/register-read stage. It owns the PC, issues reads to a synchronous instruction memory, and decodes each 16-bit word into the 7-bit virtual opcode, fields and sign-extended immediate. Decoded instructions are buffered in a small FIFO and passed downstream with a valid/ready handshake. Downstream branch resolution redirects the PC and flushes the stage.

---
 rtl/axa_fetch_decode.sv | 176 +++++++++++++++++
 tb/tb_axa_fetch_decode.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axa_fetch_decode.sv
// axa_fetch_decode: front end of the AXA core.
// Owns the PC and issues reads to a synchronous instruction memory with
// one cycle of latency. Each returned 16-bit word is decoded into virtual
// opcode, register fields and sign-extended immediate. The result is pushed
// into a small FIFO that drains downstream through a valid/ready handshake.
// A redirect from branch resolution flushes the FIFO, drops any response
// still in flight and restarts fetch at the new address.
module axa_fetch_decode #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_vop,
    output logic [3:0]  out_dest,
    output logic [3:0]  out_src,
    output logic [1:0]  out_type,
    output logic [15:0] out_imm,
    output logic [15:0] out_pc,
    output logic        out_bad,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        stopped
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;

    // One decoded instruction as held in the FIFO.
    typedef struct packed {
        logic [6:0]  vop;
        logic [3:0]  dest;
        logic [3:0]  src;
        logic [1:0]  srcType;
        logic [15:0] imm;
        logic [15:0] pc;
        logic        bad;
    } entry_t;

    // Fetch-side state.
    logic [15:0]   r_pc;
    logic [15:0]   r_reqAddr;
    logic          r_inflight;
    logic          r_discard;
    logic          r_stopped;

    // Decoded-instruction FIFO.
    entry_t        r_fifo [DEPTH];
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;

    // Combinational helpers.
    entry_t         w_dec;
    entry_t         w_head;
    logic           w_stopCause;
    logic           w_outValid;
    logic           w_pop;
    logic           w_enq;
    logic           w_issue;
    logic [CW1-1:0] w_pending;

    // True for every virtual opcode the execute stage knows how to run.
    function automatic logic isLegal(input logic [6:0] v);
        isLegal = ((v >= 7'h40) && (v <= 7'h43)) ||
                  ((v >= 7'h60) && (v <= 7'h6B)) ||
                  ((v >= 7'h70) && (v <= 7'h74)) ||
                  (v == 7'h7F);
    endfunction

    // Decode the word returned by memory; short ops carry an 8-bit split
    // immediate, long ops carry a source type and a 4-bit immediate.
    always_comb begin
        w_dec      = '0;
        w_dec.dest = imem_data[7:4];
        w_dec.src  = imem_data[3:0];
        w_dec.pc   = r_reqAddr;
        if (!imem_data[15]) begin
            w_dec.vop     = {3'b100, imem_data[15:12]};
            w_dec.srcType = 2'b00;
            w_dec.imm     = {{8{imem_data[11]}}, imem_data[11:8], imem_data[3:0]};
        end else begin
            w_dec.vop     = {1'b1, imem_data[15:10]};
            w_dec.srcType = imem_data[9:8];
            w_dec.imm     = {{12{imem_data[3]}}, imem_data[3:0]};
        end
        w_dec.bad   = !isLegal(w_dec.vop);
        w_stopCause = (w_dec.vop == 7'h71) || (w_dec.vop == 7'h7F) || w_dec.bad ||
                      (imem_data[15] && (w_dec.srcType == 2'b11));
    end

    // Handshake, enqueue and issue decisions; a redirect overrides them all.
    always_comb begin
        w_outValid = (r_count != '0);
        w_pop      = w_outValid && out_ready && !redirect;
        w_enq      = r_inflight && !r_discard && !r_stopped && !redirect;
        w_pending  = CW1'(r_count) - CW1'(w_pop) + CW1'(r_inflight);
        w_issue    = !reset && !r_stopped && !redirect && (w_pending < CW1'(DEPTH));
    end

    // PC, outstanding-request tracking, discard and stop flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_reqAddr  <= RESET_PC;
            r_inflight <= 1'b0;
            r_discard  <= 1'b0;
            r_stopped  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_discard  <= redirect && r_inflight;
            if (w_issue) begin
                r_reqAddr <= r_pc;
            end
            if (redirect) begin
                r_pc      <= redirect_pc;
                r_stopped <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + 16'd1;
                end
                if (w_enq && w_stopCause) begin
                    r_stopped <= 1'b1;
                end
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_pop);
        end
    end

    // FIFO storage; contents only matter while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo[r_wrPtr] <= w_dec;
        end
    end

    assign w_head    = r_fifo[r_rdPtr];
    assign out_valid = w_outValid;
    assign out_vop   = w_outValid ? w_head.vop     : '0;
    assign out_dest  = w_outValid ? w_head.dest    : '0;
    assign out_src   = w_outValid ? w_head.src     : '0;
    assign out_type  = w_outValid ? w_head.srcType : '0;
    assign out_imm   = w_outValid ? w_head.imm     : '0;
    assign out_pc    = w_outValid ? w_head.pc      : '0;
    assign out_bad   = w_outValid ? w_head.bad     : 1'b0;
    assign imem_req  = w_issue;
    assign imem_addr = r_pc;
    assign stopped   = r_stopped;

endmodule

// File: tb/tb_axa_fetch_decode.sv
// tb_axa_fetch_decode: directed bench for the AXA fetch/decode stage.
// A behavioural synchronous memory answers requests one cycle later.
// Inputs change on the falling edge and outputs are sampled 1ns later.
module tb_axa_fetch_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  out_vop;
    logic [3:0]  out_dest;
    logic [3:0]  out_src;
    logic [1:0]  out_type;
    logic [15:0] out_imm;
    logic [15:0] out_pc;
    logic        out_bad;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        stopped;

    int checkCount = 0;
    int passCount  = 0;

    logic [15:0] mem [0:1023];

    axa_fetch_decode #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vop(out_vop), .out_dest(out_dest), .out_src(out_src),
        .out_type(out_type), .out_imm(out_imm), .out_pc(out_pc),
        .out_bad(out_bad), .redirect(redirect), .redirect_pc(redirect_pc),
        .stopped(stopped)
    );

    // Free-running clock, 10ns period.
    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after a request.
    always @(posedge clk) begin
        if (imem_req) imem_data <= mem[imem_addr[9:0]];
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Every word defaults to a legal short op 0x41 with dest/src taken from the address.
    task automatic initMem();
        for (int i = 0; i < 1024; i++) mem[i] = {8'h10, 8'(i)};
    endtask

    // Hold reset for two cycles and release it on a falling edge (cycle 0 begins).
    task automatic doReset();
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); #1;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0h expected 0", out_valid); else passCount++;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL reset_req: got %0h expected 0", imem_req); else passCount++;
        checkCount++; if (imem_addr !== 16'h0000) $display("[TB] FAIL reset_addr: got %0h expected 0", imem_addr); else passCount++;
        checkCount++; if (stopped !== 1'b0) $display("[TB] FAIL reset_stopped: got %0h expected 0", stopped); else passCount++;
        checkCount++; if (out_vop !== 7'h00) $display("[TB] FAIL reset_vop: got %0h expected 0", out_vop); else passCount++;
        checkCount++; if (out_pc !== 16'h0000) $display("[TB] FAIL reset_pc: got %0h expected 0", out_pc); else passCount++;
        checkCount++; if (out_imm !== 16'h0000) $display("[TB] FAIL reset_imm: got %0h expected 0", out_imm); else passCount++;
        checkCount++; if (out_bad !== 1'b0) $display("[TB] FAIL reset_bad: got %0h expected 0", out_bad); else passCount++;
    endtask

    task automatic test_fetch_stream();
        initMem();
        mem[0] = 16'h1234;
        doReset();
        out_ready = 1'b1;
        #1;
        checkCount++; if (imem_req !== 1'b1) $display("[TB] FAIL stream_req0: got %0h expected 1", imem_req); else passCount++;
        checkCount++; if (imem_addr !== 16'h0000) $display("[TB] FAIL stream_addr0: got %0h expected 0", imem_addr); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL stream_valid0: got %0h expected 0", out_valid); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (imem_addr !== 16'h0001) $display("[TB] FAIL stream_addr1: got %0h expected 1", imem_addr); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL stream_valid1: got %0h expected 0", out_valid); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (imem_addr !== 16'h0002) $display("[TB] FAIL stream_addr2: got %0h expected 2", imem_addr); else passCount++;
        checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL stream_valid2: got %0h expected 1", out_valid); else passCount++;
        checkCount++; if (out_vop !== 7'h41) $display("[TB] FAIL stream_vop: got %0h expected 41", out_vop); else passCount++;
        checkCount++; if (out_dest !== 4'h3) $display("[TB] FAIL stream_dest: got %0h expected 3", out_dest); else passCount++;
        checkCount++; if (out_src !== 4'h4) $display("[TB] FAIL stream_src: got %0h expected 4", out_src); else passCount++;
        checkCount++; if (out_imm !== 16'h0024) $display("[TB] FAIL stream_imm: got %0h expected 0024", out_imm); else passCount++;
        checkCount++; if (out_type !== 2'b00) $display("[TB] FAIL stream_type: got %0h expected 0", out_type); else passCount++;
        checkCount++; if (out_pc !== 16'h0000) $display("[TB] FAIL stream_pc0: got %0h expected 0", out_pc); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (out_pc !== 16'h0001) $display("[TB] FAIL stream_pc1: got %0h expected 1", out_pc); else passCount++;
        checkCount++; if (out_src !== 4'h1) $display("[TB] FAIL stream_src1: got %0h expected 1", out_src); else passCount++;
    endtask

    task automatic test_decode_stop();
        initMem();
        mem[0] = 16'hC0F8;
        mem[1] = 16'h8F25;
        doReset();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checkCount++; if (out_vop !== 7'h70) $display("[TB] FAIL jnz_vop: got %0h expected 70", out_vop); else passCount++;
        checkCount++; if (out_imm !== 16'hFFF8) $display("[TB] FAIL jnz_imm: got %0h expected fff8", out_imm); else passCount++;
        checkCount++; if (stopped !== 1'b0) $display("[TB] FAIL jnz_stopped: got %0h expected 0", stopped); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (out_vop !== 7'h63) $display("[TB] FAIL sub_vop: got %0h expected 63", out_vop); else passCount++;
        checkCount++; if (out_type !== 2'b11) $display("[TB] FAIL sub_type: got %0h expected 3", out_type); else passCount++;
        checkCount++; if (out_dest !== 4'h2) $display("[TB] FAIL sub_dest: got %0h expected 2", out_dest); else passCount++;
        checkCount++; if (out_imm !== 16'h0005) $display("[TB] FAIL sub_imm: got %0h expected 0005", out_imm); else passCount++;
        checkCount++; if (out_bad !== 1'b0) $display("[TB] FAIL sub_bad: got %0h expected 0", out_bad); else passCount++;
        checkCount++; if (stopped !== 1'b1) $display("[TB] FAIL sub_stopped: got %0h expected 1", stopped); else passCount++;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL sub_req: got %0h expected 0", imem_req); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL sub_drop: got %0h expected 0", out_valid); else passCount++;
        repeat (3) @(negedge clk);
        #1;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL sub_req_later: got %0h expected 0", imem_req); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL sub_valid_later: got %0h expected 0", out_valid); else passCount++;
    endtask

    task automatic test_backpressure();
        logic [15:0] expPc;
        initMem();
        doReset();
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL bp_req_c2: got %0h expected 0", imem_req); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL bp_req_full: got %0h expected 0", imem_req); else passCount++;
        checkCount++; if (out_pc !== 16'h0000) $display("[TB] FAIL bp_head_stable: got %0h expected 0", out_pc); else passCount++;
        checkCount++; if (imem_addr !== 16'h0002) $display("[TB] FAIL bp_pc_held: got %0h expected 2", imem_addr); else passCount++;
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checkCount++; if (imem_req !== 1'b1) $display("[TB] FAIL bp_req_release: got %0h expected 1", imem_req); else passCount++;
        expPc = 16'h0000;
        for (int c = 0; c < 4; c++) begin
            checkCount++; if (out_valid !== 1'b1 || out_pc !== expPc) $display("[TB] FAIL bp_drain%0d: got valid=%0h pc=%0h expected valid=1 pc=%0h", c, out_valid, out_pc, expPc); else passCount++;
            expPc = expPc + 16'd1;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        initMem();
        mem[256] = 16'h0ABC;
        doReset();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0100;
        #1;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL redir_req_same: got %0h expected 0", imem_req); else passCount++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL redir_flushed: got %0h expected 0", out_valid); else passCount++;
        checkCount++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) $display("[TB] FAIL redir_first_req: got req=%0h addr=%0h expected req=1 addr=0100", imem_req, imem_addr); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL redir_no_stale: got %0h expected 0", out_valid); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (out_valid !== 1'b1 || out_pc !== 16'h0100) $display("[TB] FAIL redir_out_pc: got valid=%0h pc=%0h expected valid=1 pc=0100", out_valid, out_pc); else passCount++;
        checkCount++; if (out_vop !== 7'h40) $display("[TB] FAIL redir_vop: got %0h expected 40", out_vop); else passCount++;
        checkCount++; if (out_imm !== 16'hFFAC) $display("[TB] FAIL redir_imm: got %0h expected ffac", out_imm); else passCount++;
    endtask

    task automatic test_back_to_back();
        initMem();
        doReset();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0200;
        @(negedge clk);
        redirect_pc = 16'h0100;
        #1;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL b2b_req: got %0h expected 0", imem_req); else passCount++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checkCount++; if (imem_addr !== 16'h0100) $display("[TB] FAIL b2b_last_wins: got %0h expected 0100", imem_addr); else passCount++;
        @(negedge clk);
        @(negedge clk); #1;
        checkCount++; if (out_valid !== 1'b1 || out_pc !== 16'h0100) $display("[TB] FAIL b2b_out_pc: got valid=%0h pc=%0h expected valid=1 pc=0100", out_valid, out_pc); else passCount++;
    endtask

    task automatic test_sys_stop();
        initMem();
        mem[5] = 16'hFC00;
        doReset();
        out_ready = 1'b1;
        repeat (7) @(negedge clk);
        #1;
        checkCount++; if (out_valid !== 1'b1 || out_vop !== 7'h7F || out_pc !== 16'h0005) $display("[TB] FAIL sys_entry: got valid=%0h vop=%0h pc=%0h expected valid=1 vop=7f pc=5", out_valid, out_vop, out_pc); else passCount++;
        checkCount++; if (stopped !== 1'b1 || imem_req !== 1'b0) $display("[TB] FAIL sys_stopped: got stopped=%0h req=%0h expected stopped=1 req=0", stopped, imem_req); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL sys_next_dropped: got %0h expected 0", out_valid); else passCount++;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0000;
        #1;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL sys_redir_req: got %0h expected 0", imem_req); else passCount++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checkCount++; if (stopped !== 1'b0) $display("[TB] FAIL sys_restart_stopped: got %0h expected 0", stopped); else passCount++;
        checkCount++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) $display("[TB] FAIL sys_restart_req: got req=%0h addr=%0h expected req=1 addr=0", imem_req, imem_addr); else passCount++;
        @(negedge clk);
        @(negedge clk); #1;
        checkCount++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) $display("[TB] FAIL sys_restart_out: got valid=%0h pc=%0h expected valid=1 pc=0", out_valid, out_pc); else passCount++;
    endtask

    task automatic test_bad_op();
        initMem();
        mem[0] = 16'h5000;
        doReset();
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checkCount++; if (out_vop !== 7'h45 || out_bad !== 1'b1) $display("[TB] FAIL bad_entry: got vop=%0h bad=%0h expected vop=45 bad=1", out_vop, out_bad); else passCount++;
        checkCount++; if (stopped !== 1'b1 || imem_req !== 1'b0) $display("[TB] FAIL bad_stopped: got stopped=%0h req=%0h expected stopped=1 req=0", stopped, imem_req); else passCount++;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk); #1;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL bad_followup_dropped: got %0h expected 0", out_valid); else passCount++;
    endtask

    task automatic test_reset_midstream();
        initMem();
        doReset();
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checkCount++; if (out_valid !== 1'b1 || out_pc !== 16'h0002) $display("[TB] FAIL mid_stream: got valid=%0h pc=%0h expected valid=1 pc=2", out_valid, out_pc); else passCount++;
        #2;
        reset = 1'b1;
        #1;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_reset_valid: got %0h expected 0", out_valid); else passCount++;
        checkCount++; if (imem_addr !== 16'h0000 || imem_req !== 1'b0) $display("[TB] FAIL mid_reset_pc: got addr=%0h req=%0h expected addr=0 req=0", imem_addr, imem_req); else passCount++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkCount++; if (out_valid !== 1'b0 || imem_addr !== 16'h0000) $display("[TB] FAIL mid_restart: got valid=%0h addr=%0h expected valid=0 addr=0", out_valid, imem_addr); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_stale_ignored: got %0h expected 0", out_valid); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) $display("[TB] FAIL mid_first_out: got valid=%0h pc=%0h expected valid=1 pc=0", out_valid, out_pc); else passCount++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        initMem();
        test_reset();
        test_fetch_stream();
        test_decode_stop();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_sys_stop();
        test_bad_op();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
